instr_mem_loader: RTL

- Writer side of the instruction memory that integrated_cpu fetches from. Receives a framed byte stream (host/UART side) and assembles little-endian 32-bit words. Writes them sequentially into the instruction memory write port.
- Holds the CPU in reset while a load is in progress, then releases it. The CPU restarts from word 0.
- Replaces simulation-only preloading of the instruction memory, giving a synthesizable load path on the board.

---
 rtl/instr_mem_loader_if.sv | 49 ++++
 rtl/instr_mem_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_if
// Groups the byte-stream handshake and the instruction-memory write port of
// the instruction memory loader.
//
// Handshake: a byte moves from the host to the loader on a rising clock edge
// where byte_valid and byte_ready are both 1. byte_data is only meaningful
// while byte_valid is 1. byte_ready does not depend on byte_valid.
//
// Signals:
//   byte_valid   host -> loader  byte_data valid this cycle
//   byte_data    host -> loader  incoming stream byte
//   byte_ready   loader -> host  loader accepts a byte this cycle
//   mem_wr_en    loader -> mem   one-cycle write strobe
//   mem_wr_addr  loader -> mem   word address
//   mem_wr_data  loader -> mem   32-bit word
//
// Modports:
//   loader : the loader side (slave of the byte stream, master of memory)
//   host   : the environment side (byte source and memory sink)
// ---------------------------------------------------------------------------
interface instr_mem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;

    modport loader (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data
    );

    modport host (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data
    );
endinterface

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
// Writer side of the CPU instruction memory. Parses a framed byte stream
//   SYNC_BYTE, LEN_LO, LEN_HI, LEN x {b0,b1,b2,b3}, CHK
// assembles little-endian 32-bit words and writes them to consecutive word
// addresses starting at 0. CHK is the XOR of the two length bytes and all
// data bytes. The CPU is held in reset from the sync byte until a frame
// completes with a good checksum.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   bus          byte stream + memory write port (loader modport)
//   cpu_hold     CPU reset request (CPU held while 1)
//   load_done    last frame completed with good checksum
//   load_error   last frame rejected (bad checksum or oversize length)
//   dbg_state_o  current FSM state, for observation only
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_mem_loader_if.loader    bus,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // Largest accepted word count: the whole memory.
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [15:0]       len_q,   len_d;
    logic [15:0]       cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [1:0]        idx_q,   idx_d;
    logic [31:0]       word_q,  word_d;
    logic [7:0]        chk_q,   chk_d;
    logic              hold_q,  hold_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;

    logic              take;
    logic [16:0]       len_full;

    assign take     = bus.byte_valid & bus.byte_ready;
    // Full length as it becomes known during the LEN_HI transfer.
    assign len_full = {1'b0, bus.byte_data, len_q[7:0]};

    assign bus.byte_ready  = (state_q != S_WRITE);
    assign bus.mem_wr_en   = (state_q == S_WRITE);
    assign bus.mem_wr_addr = addr_q;
    assign bus.mem_wr_data = word_q;
    assign cpu_hold        = hold_q;
    assign load_done       = done_q;
    assign load_error      = err_q;
    assign dbg_state_o     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            chk_q   <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            chk_q   <= chk_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        word_d  = word_q;
        chk_d   = chk_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // Anything other than the sync byte is consumed and dropped.
                if (take && bus.byte_data == SYNC_BYTE) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    chk_d   = '0;
                    addr_d  = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    hold_d  = 1'b1;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (take) begin
                    len_d[7:0] = bus.byte_data;
                    chk_d      = chk_q ^ bus.byte_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (take) begin
                    len_d[15:8] = bus.byte_data;
                    chk_d       = chk_q ^ bus.byte_data;
                    if (len_full == 17'd0) begin
                        state_d = S_CHECK;
                    end else if (len_full > MAX_WORDS) begin
                        // Rejecting here is what keeps addr_q from wrapping.
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    word_d[{idx_q, 3'b000} +: 8] = bus.byte_data;
                    chk_d = chk_q ^ bus.byte_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // The strobe is visible this cycle; bookkeeping lands at the edge.
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q + 16'd1;
                idx_d  = '0;
                if (cnt_q + 16'd1 == len_q) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHECK: begin
                if (take) begin
                    if (bus.byte_data == chk_q) begin
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
